pu_fifo_buffer: RTL and testbench
=================================

Name: pu_fifo_buffer

Overview:
Bus-attached FIFO processing unit. It sits directly downstream of pu_accum on the data/attr bus, and can also sit upstream of it.
- Captures {attr, data} words driven on the bus (for example accumulator results carrying SIGN/OVERFLOW) in arrival order.
- Replays them onto the bus on demand.
- Lets the scheduler decouple accumulator producers from later consumers without occupying accumulator registers.

Parameters:
DATA_WIDTH, 32, data word width
ATTR_WIDTH, 4, attribute word width
DEPTH, 8, number of entries; power of 2, >= 2
SIGN, 0, attr bit index of sign flag (stored and replayed unchanged)
OVERFLOW, 1, attr bit index of overflow/error flag

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
signal_wr  in  1  push {attr_in, data_in} this cycle
signal_oe  in  1  pop head and drive it onto the bus next cycle
signal_clr  in  1  flush FIFO and clear sticky error
data_in  in  DATA_WIDTH  bus data
attr_in  in  ATTR_WIDTH  bus attributes
data_out  out  DATA_WIDTH  registered bus data, 0 when not driving
attr_out  out  ATTR_WIDTH  registered bus attributes, 0 when not driving
full  out  1  count == DEPTH (combinational from count register)
empty  out  1  count == 0 (combinational from count register)

Behaviour:
Interface: reset rst, synchronous, active-high; clock clk.

Reset:
- wr_ptr, rd_ptr, count, lost_flag cleared to 0.
- data_out = 0, attr_out = 0; empty = 1, full = 0.
- Memory contents are don't-care.
- rst in mid-operation discards all entries at that edge.

State: wr_ptr and rd_ptr ($clog2(DEPTH) bits), count ($clog2(DEPTH+1) bits), lost_flag (sticky).
- Pointers wrap DEPTH-1 -> 0 by natural overflow.

Write:
- signal_wr && !full (evaluated before this cycle's pop): mem[wr_ptr] <= {attr_in, data_in}; wr_ptr++.
- signal_wr && full && !signal_oe: word dropped, pointers unchanged, lost_flag <= 1.

Read:
- signal_oe && !empty: data_out/attr_out <= mem[rd_ptr] at this edge, visible the following cycle (1-cycle latency); rd_ptr++.
- Returned attr_out[OVERFLOW] = stored OVERFLOW | lost_flag.
- lost_flag clears on that read.
- signal_oe && empty (underflow): data_out <= 0, attr_out <= 0 except attr_out[OVERFLOW] <= 1; pointers unchanged.
- !signal_oe: {attr_out, data_out} <= 0, so the output can be OR-ed onto the shared bus.

Simultaneous wr + oe:
- Not empty, not full: push and pop both occur; count unchanged.
- Full: pop occurs and the write is accepted into the freed slot; count stays DEPTH; nothing lost.
- Empty: write accepted, read is an underflow (no bypass); count becomes 1.

count:
- +1 on accepted write without pop.
- -1 on pop without accepted write.
- Unchanged otherwise.

signal_clr:
- Next edge: pointers, count, lost_flag <= 0; outputs <= 0.
- Overrides signal_wr and signal_oe in the same cycle.

Width rules: no arithmetic on data; attr bits other than OVERFLOW are replayed verbatim.

Decomposition:
- Shared include pu_attr.vh holds the SIGN/OVERFLOW default bit indices, used by pu_accum and all bus PUs.
- Single sub-module pu_fifo_mem: simple dual-port RAM, DEPTH x (ATTR_WIDTH+DATA_WIDTH).
  - Synchronous write.
  - Registered read with enable, so it maps to block/distributed RAM.
- Pointer, count and flag control stay in pu_fifo_buffer.

Test Plan:
DATA_WIDTH=8, ATTR_WIDTH=4, DEPTH=4.
1. Reset, then oe for 1 cycle -> next cycle data_out=0x00, attr_out=0b0010 (underflow); empty=1 throughout.
2. Push 0x11/a=0, 0x22/a=1 (SIGN), 0x33/a=2; then oe x3 -> outputs 0x11/0, 0x22/1, 0x33/2 on consecutive cycles, 1 cycle after each oe; then empty=1.
3. Push 0x01..0x04 (full=1), push 0x05 -> dropped; oe x4 -> 0x01 with attr_out[OVERFLOW]=1, then 0x02, 0x03, 0x04 with OVERFLOW=0.
4. Full FIFO, wr 0x99 + oe same cycle -> out 0x01, count stays 4; subsequent pops yield 0x02, 0x03, 0x04, 0x99 (wrap verified).
5. Empty FIFO, wr 0x55 + oe same cycle -> underflow output (0x00, OVERFLOW=1); next oe -> 0x55/0.
6. Three entries stored, assert clr with wr+oe same cycle -> outputs 0, empty=1, count=0; following oe -> underflow. Also assert rst mid-stream -> same result.

Source files
------------

// File: rtl/pu_fifo_buffer_pkg.sv
// Shared definitions for the bus FIFO processing unit: default attribute
// bit positions and the output-stage selector encoding.
package pu_fifo_buffer_pkg;

    // Default attribute bit indices shared with pu_accum and the other bus PUs
    localparam int unsigned DEF_SIGN     = 0;
    localparam int unsigned DEF_OVERFLOW = 1;

    // What the registered output stage drives onto the bus this cycle
    typedef enum logic [1:0] {
        OUT_IDLE  = 2'd0,  // not driving: all zeros
        OUT_DATA  = 2'd1,  // replaying a popped entry
        OUT_UNDER = 2'd2   // pop requested on an empty FIFO
    } out_sel_t;

endpackage : pu_fifo_buffer_pkg

// File: rtl/pu_fifo_mem.sv
// Simple dual-port RAM for the FIFO: synchronous write, registered read with
// enable so that it maps onto block or distributed RAM.
module pu_fifo_mem #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port; same-address write in the same cycle returns the old word
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : pu_fifo_mem

// File: rtl/pu_fifo_buffer.sv
// Bus-attached FIFO: captures {attr, data} words from the bus in arrival
// order and replays them on demand, one cycle after each pop request.
// Outputs are zero when not driving so they can be OR-ed onto the bus.
module pu_fifo_buffer
    import pu_fifo_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ATTR_WIDTH = 4,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned SIGN       = DEF_SIGN,
    parameter int unsigned OVERFLOW   = DEF_OVERFLOW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_wr,
    input  logic                  signal_oe,
    input  logic                  signal_clr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned WORD_W = ATTR_WIDTH + DATA_WIDTH;

    // Elaboration-time parameter sanity
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pu_fifo_buffer: DEPTH must be a power of 2 and >= 2");
    end
    if ((SIGN >= ATTR_WIDTH) || (OVERFLOW >= ATTR_WIDTH) || (SIGN == OVERFLOW)) begin : g_bad_attr
        $error("pu_fifo_buffer: SIGN/OVERFLOW must be distinct bits within ATTR_WIDTH");
    end

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              lost_flag;
    out_sel_t          out_sel;
    logic              out_lost;
    logic [WORD_W-1:0] rd_word;
    logic              flush;
    logic              pop;
    logic              push;
    logic              drop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO still accepts a write when the same cycle pops: the new
    // word lands in the slot being vacated (RAM returns the old word first).
    assign flush = rst | signal_clr;
    assign pop   = signal_oe & ~empty & ~flush;
    assign push  = signal_wr & (~full | signal_oe) & ~flush;
    assign drop  = signal_wr & full & ~signal_oe & ~flush;

    pu_fifo_mem #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk    (clk),
        .wr_en  (push),
        .wr_addr(wr_ptr),
        .wr_data({attr_in, data_in}),
        .rd_en  (pop),
        .rd_addr(rd_ptr),
        .rd_data(rd_word)
    );

    // Pointer, occupancy and sticky lost-word tracking
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            lost_flag <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (pop) begin
                lost_flag <= 1'b0;
            end else if (drop) begin
                lost_flag <= 1'b1;
            end
        end
    end

    // Output-stage selector, registered alongside the RAM read
    always_ff @(posedge clk) begin
        if (flush) begin
            out_sel  <= OUT_IDLE;
            out_lost <= 1'b0;
        end else if (pop) begin
            out_sel  <= OUT_DATA;
            out_lost <= lost_flag;
        end else if (signal_oe) begin
            out_sel  <= OUT_UNDER;
            out_lost <= 1'b0;
        end else begin
            out_sel  <= OUT_IDLE;
            out_lost <= 1'b0;
        end
    end

    // Bus drive: replayed word (with lost-word flag folded into OVERFLOW),
    // underflow marker, or zeros
    always_comb begin
        data_out = '0;
        attr_out = '0;
        case (out_sel)
            OUT_DATA: begin
                data_out           = rd_word[DATA_WIDTH-1:0];
                attr_out           = rd_word[WORD_W-1:DATA_WIDTH];
                attr_out[OVERFLOW] = rd_word[DATA_WIDTH + OVERFLOW] | out_lost;
            end
            OUT_UNDER: begin
                attr_out[OVERFLOW] = 1'b1;
            end
            default: begin
                data_out = '0;
                attr_out = '0;
            end
        endcase
    end

endmodule : pu_fifo_buffer

// File: tb/tb_pu_fifo_buffer.sv
// Self-checking bench for pu_fifo_buffer (8-bit data, 4-bit attr, depth 4):
// directed scenarios followed by random traffic, all checked against a
// queue-based reference model.
module tb_pu_fifo_buffer;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OVF = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          signal_wr = 1'b0;
    logic          signal_oe = 1'b0;
    logic          signal_clr = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW-1:0] attr_in = '0;
    logic [DW-1:0] data_out;
    logic [AW-1:0] attr_out;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [AW+DW-1:0] model_q[$];
    logic             model_lost = 1'b0;
    logic [DW-1:0]    exp_data = '0;
    logic [AW-1:0]    exp_attr = '0;

    pu_fifo_buffer #(
        .DATA_WIDTH(DW),
        .ATTR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .SIGN      (0),
        .OVERFLOW  (OVF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .signal_wr (signal_wr),
        .signal_oe (signal_oe),
        .signal_clr(signal_clr),
        .data_in   (data_in),
        .attr_in   (attr_in),
        .data_out  (data_out),
        .attr_out  (attr_out),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock with the given inputs
    task automatic model_step(input logic r, input logic c, input logic w, input logic o,
                              input logic [DW-1:0] d, input logic [AW-1:0] a);
        logic [AW+DW-1:0] word;
        int               sz;
        sz = model_q.size();
        exp_data = '0;
        exp_attr = '0;
        if (r || c) begin
            model_q.delete();
            model_lost = 1'b0;
        end else begin
            if (o) begin
                if (sz > 0) begin
                    word = model_q.pop_front();
                    exp_data = word[DW-1:0];
                    exp_attr = word[AW+DW-1:DW];
                    if (model_lost) exp_attr[OVF] = 1'b1;
                    model_lost = 1'b0;
                end else begin
                    exp_attr[OVF] = 1'b1;
                end
            end
            if (w) begin
                if (sz < int'(DEPTH) || o) model_q.push_back({a, d});
                else model_lost = 1'b1;
            end
        end
    endtask

    // Drive one cycle, then compare every output against the model
    task automatic cycle(input string tag, input logic r, input logic c, input logic w,
                         input logic o, input logic [DW-1:0] d, input logic [AW-1:0] a);
        rst = r; signal_clr = c; signal_wr = w; signal_oe = o;
        data_in = d; attr_in = a;
        model_step(r, c, w, o, d, a);
        @(posedge clk);
        #1;
        rst = 1'b0; signal_clr = 1'b0; signal_wr = 1'b0; signal_oe = 1'b0;
        check({tag, ".data"},  32'(data_out), 32'(exp_data));
        check({tag, ".attr"},  32'(attr_out), 32'(exp_attr));
        check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, ".full"},  32'(full), 32'(model_q.size() == int'(DEPTH)));
    endtask

    task automatic push(input string tag, input logic [DW-1:0] d, input logic [AW-1:0] a);
        cycle(tag, 1'b0, 1'b0, 1'b1, 1'b0, d, a);
    endtask

    task automatic pop(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // 1. reset, then underflow
        cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        pop("underflow_req");
        check("underflow.attr_const", 32'(attr_out), 32'h2);
        idle("underflow_after");

        // 2. basic order
        push("t2.push", 8'h11, 4'd0);
        push("t2.push", 8'h22, 4'd1);
        push("t2.push", 8'h33, 4'd2);
        for (int i = 0; i < 3; i++) pop("t2.pop");
        idle("t2.drain");

        // 3. overflow drop and sticky lost flag
        for (int i = 1; i <= 4; i++) push("t3.fill", 8'(i), 4'd0);
        push("t3.drop", 8'h05, 4'd0);
        for (int i = 0; i < 4; i++) pop("t3.pop");
        idle("t3.drain");

        // 4. full + simultaneous wr/oe wraps into freed slot
        for (int i = 1; i <= 4; i++) push("t4.fill", 8'(i), 4'd0);
        cycle("t4.wr_oe", 1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 4'd0);
        check("t4.full_kept", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) pop("t4.pop");
        idle("t4.drain");

        // 5. empty + simultaneous wr/oe: underflow, no bypass
        cycle("t5.wr_oe", 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 4'd0);
        pop("t5.pop");
        idle("t5.drain");

        // 6. clear overrides wr+oe; reset mid-stream
        for (int i = 0; i < 3; i++) push("t6.fill", 8'(8'hA0 + i), 4'(i));
        cycle("t6.clr", 1'b0, 1'b1, 1'b1, 1'b1, 8'hEE, 4'hF);
        pop("t6.after_clr");
        for (int i = 0; i < 3; i++) push("t6.refill", 8'(8'hB0 + i), 4'(i));
        cycle("t6.rst", 1'b1, 1'b0, 1'b1, 1'b1, 8'hEE, 4'hF);
        pop("t6.after_rst");
        idle("t6.drain");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle("rand",
                  ($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 99) < 55),
                  ($urandom_range(0, 99) < 45),
                  8'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pu_fifo_buffer
